// File: rtl/ram_module_param.sv
// ram_module_param: core-local dual-port byte-lane memory, big-endian.
// Port A is the instruction fetch port (IR). Port B is the data port with
// BYTE/WORD/LONG access, sign extension and misalignment rejection. It also
// has a one-word UART window and a zero-clear sequencer that runs after reset.
module ram_module_param #(
  parameter int                ADDR_W         = 15,
  parameter bit                PIPE_OUT       = 1'b1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [ADDR_W-1:0] UART_ADDR      = ADDR_W'(15'h7FFC)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Paddr,
  output logic [31:0]       IR,
  input  logic [ADDR_W-1:0] Daddr,
  input  logic [31:0]       datain,
  input  logic [1:0]        access_mode,
  input  logic              M_signed,
  input  logic              wren,
  input  logic              dreq,
  output logic              ready,
  output logic [31:0]       MOUT,
  output logic              mout_valid,
  output logic              misalign_err,
  input  logic [7:0]        uread_port,
  input  logic              write_busy,
  output logic              uart_we,
  output logic [7:0]        uart_wdata,
  output logic              clear_busy
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;

  // Access mode encodings; 2'b11 is treated as LONG.
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_WORD = 2'b01;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_TXWAIT} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   clr_cnt_reg;
  logic [WORD_W-1:0]   d_word, p_word, b_addr;
  logic                is_byte, is_word, is_long, misaligned, is_uart;
  logic                accept_wr, accept_rd, uart_store, ram_store;
  logic [3:0]          lane_sel, b_we;
  logic [31:0]         wdata_b, b_wdata, rd_word;

  logic                uart_we_reg;
  logic [7:0]          uart_wdata_reg, tx_byte_reg;
  logic                mis_err_reg;
  logic                ld_v1_reg, ld_sgn_reg, ld_uart_reg, ld_mis_reg;
  logic [1:0]          ld_off_reg, ld_mode_reg;
  logic [31:0]         ld_uval_reg, ld_data;
  logic [31:0]         mout_reg;
  logic                mv_reg;
  logic [7:0]          ext_byte;
  logic [15:0]         ext_half;

  // Fetch addresses are word addresses; the low two bits carry no meaning.
  logic unused_paddr_bits;
  assign unused_paddr_bits = ^Paddr[1:0];

  assign d_word = Daddr[ADDR_W-1:2];
  assign p_word = Paddr[ADDR_W-1:2];

  assign ready      = (state_reg == ST_RUN);
  assign clear_busy = (state_reg == ST_CLEAR);

  assign is_byte    = (access_mode == MODE_BYTE);
  assign is_word    = (access_mode == MODE_WORD);
  assign is_long    = access_mode[1];
  assign misaligned = (is_word & Daddr[0]) | (is_long & (Daddr[1:0] != 2'b00));
  assign is_uart    = (d_word == UART_ADDR[ADDR_W-1:2]);

  // A store beats a load when both are requested in the same cycle.
  assign accept_wr  = ready & wren;
  assign accept_rd  = ready & dreq & ~wren;
  assign uart_store = accept_wr & is_uart & ~misaligned;
  assign ram_store  = accept_wr & ~is_uart & ~misaligned;

  // Big-endian lane enables and replicated store data (lane 0 = bits [31:24]).
  always_comb begin
    lane_sel = 4'b0000;
    wdata_b  = datain;
    if (is_byte) begin
      lane_sel[Daddr[1:0]] = 1'b1;
      wdata_b              = {4{datain[7:0]}};
    end else if (is_word) begin
      wdata_b = {2{datain[15:0]}};
      if (Daddr[1]) lane_sel = 4'b1100;
      else          lane_sel = 4'b0011;
    end else begin
      lane_sel = 4'b1111;
    end
  end

  // Port B is shared between the clear sequencer and data accesses.
  assign b_addr  = clear_busy ? clr_cnt_reg : d_word;
  assign b_wdata = clear_busy ? 32'h0 : wdata_b;
  assign b_we    = clear_busy ? 4'b1111 : (ram_store ? lane_sel : 4'b0000);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] ir_q;
      logic [7:0] rd_q;

      // One byte lane: read-first on both ports, so a same-word fetch sees old data.
      always_ff @(posedge clock) begin
        if (b_we[gi]) mem[b_addr] <= b_wdata[31-8*gi -: 8];
        ir_q <= mem[p_word];
        rd_q <= mem[b_addr];
      end

      assign IR[31-8*gi -: 8]      = ir_q;
      assign rd_word[31-8*gi -: 8] = rd_q;
    end
  endgenerate

  // State register and clear counter; reset restarts the clear at word 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= RESET_STATE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_CLEAR) clr_cnt_reg <= clr_cnt_reg + WORD_W'(1);
      else                       clr_cnt_reg <= '0;
    end
  end

  // Next-state logic: clear sweep, run, and stall while the transmitter is busy.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR:  if (clr_cnt_reg == WORD_W'(DEPTH - 1)) state_next = ST_RUN;
      ST_RUN:    if (uart_store && write_busy) state_next = ST_TXWAIT;
      ST_TXWAIT: if (!write_busy) state_next = ST_RUN;
      default:   state_next = RESET_STATE;
    endcase
  end

  // UART transmit strobe and byte; a blocked store is held until the line frees.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uart_we_reg    <= 1'b0;
      uart_wdata_reg <= 8'h00;
      tx_byte_reg    <= 8'h00;
    end else begin
      uart_we_reg <= 1'b0;
      if (uart_store) tx_byte_reg <= datain[7:0];
      if (uart_store && !write_busy) begin
        uart_we_reg    <= 1'b1;
        uart_wdata_reg <= datain[7:0];
      end else if (state_reg == ST_TXWAIT && !write_busy) begin
        uart_we_reg    <= 1'b1;
        uart_wdata_reg <= tx_byte_reg;
      end
    end
  end

  // Load request stage: remember what the returning RAM word must be turned into.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mis_err_reg <= 1'b0;
      ld_v1_reg   <= 1'b0;
      ld_off_reg  <= 2'b00;
      ld_mode_reg <= 2'b00;
      ld_sgn_reg  <= 1'b0;
      ld_uart_reg <= 1'b0;
      ld_mis_reg  <= 1'b0;
      ld_uval_reg <= 32'h0;
    end else begin
      mis_err_reg <= (accept_wr | accept_rd) & misaligned;
      ld_v1_reg   <= accept_rd;
      if (accept_rd) begin
        ld_off_reg  <= Daddr[1:0];
        ld_mode_reg <= access_mode;
        ld_sgn_reg  <= M_signed;
        ld_uart_reg <= is_uart & ~misaligned;
        ld_mis_reg  <= misaligned;
        ld_uval_reg <= {23'b0, write_busy, uread_port};
      end
    end
  end

  // Lane extraction and zero/sign extension of the returned word.
  always_comb begin
    ext_half = ld_off_reg[1] ? rd_word[15:0] : rd_word[31:16];
    case (ld_off_reg)
      2'd0:    ext_byte = rd_word[31:24];
      2'd1:    ext_byte = rd_word[23:16];
      2'd2:    ext_byte = rd_word[15:8];
      default: ext_byte = rd_word[7:0];
    endcase
    if (ld_mis_reg)                    ld_data = 32'h0;
    else if (ld_uart_reg)              ld_data = ld_uval_reg;
    else if (ld_mode_reg == MODE_BYTE) ld_data = {{24{ld_sgn_reg & ext_byte[7]}}, ext_byte};
    else if (ld_mode_reg == MODE_WORD) ld_data = {{16{ld_sgn_reg & ext_half[15]}}, ext_half};
    else                               ld_data = rd_word;
  end

  // Output stage: MOUT keeps the last valid load result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mout_reg <= 32'h0;
      mv_reg   <= 1'b0;
    end else begin
      mv_reg <= ld_v1_reg;
      if (ld_v1_reg) mout_reg <= ld_data;
    end
  end

  generate
    if (PIPE_OUT) begin : g_pipe
      assign MOUT       = mout_reg;
      assign mout_valid = mv_reg;
    end else begin : g_comb
      assign MOUT       = ld_v1_reg ? ld_data : mout_reg;
      assign mout_valid = ld_v1_reg;
    end
  endgenerate

  assign misalign_err = mis_err_reg;
  assign uart_we      = uart_we_reg;
  assign uart_wdata   = uart_wdata_reg;

endmodule

// File: tb/tb_ram_module_param.sv
// tb_ram_module_param: directed vectors against two instances (PIPE_OUT=1 and 0).
module tb_ram_module_param;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] WORD = 2'b01;
  localparam logic [1:0] LONG = 2'b10;

  logic        clock, reset_n;
  logic [5:0]  Paddr, Daddr;
  logic [31:0] datain;
  logic [1:0]  access_mode;
  logic        M_signed, wren, dreq, write_busy;
  logic [7:0]  uread_port;

  logic [31:0] IR_p1, MOUT_p1, IR_p0, MOUT_p0;
  logic        ready_p1, mv_p1, mis_p1, uwe_p1, cb_p1;
  logic        ready_p0, mv_p0, mis_p0, uwe_p0, cb_p0;
  logic [7:0]  uwd_p1, uwd_p0;

  int n_pass = 0;
  int n_total = 0;

  ram_module_param #(.ADDR_W(6), .PIPE_OUT(1'b1), .CLEAR_ON_RESET(1'b1), .UART_ADDR(6'h3C)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .Paddr(Paddr), .IR(IR_p1), .Daddr(Daddr),
    .datain(datain), .access_mode(access_mode), .M_signed(M_signed), .wren(wren),
    .dreq(dreq), .ready(ready_p1), .MOUT(MOUT_p1), .mout_valid(mv_p1),
    .misalign_err(mis_p1), .uread_port(uread_port), .write_busy(write_busy),
    .uart_we(uwe_p1), .uart_wdata(uwd_p1), .clear_busy(cb_p1));

  ram_module_param #(.ADDR_W(6), .PIPE_OUT(1'b0), .CLEAR_ON_RESET(1'b1), .UART_ADDR(6'h3C)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .Paddr(Paddr), .IR(IR_p0), .Daddr(Daddr),
    .datain(datain), .access_mode(access_mode), .M_signed(M_signed), .wren(wren),
    .dreq(dreq), .ready(ready_p0), .MOUT(MOUT_p0), .mout_valid(mv_p0),
    .misalign_err(mis_p0), .uread_port(uread_port), .write_busy(write_busy),
    .uart_we(uwe_p0), .uart_wdata(uwd_p0), .clear_busy(cb_p0));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          ld;
    logic [1:0]  mode;
    logic [5:0]  addr;
    logic [31:0] data;
    bit          sgn;
    logic [31:0] exp;
    bit          mis;
    string       name;
  } vec_t;

  vec_t vecs [20];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Counts clear cycles with a bound; ready must stay low throughout.
  task automatic wait_clear(input string name);
    int cnt = 0;
    bit rdy_seen = 0;
    while (cb_p1 && cnt < 200) begin
      if (ready_p1 || ready_p0) rdy_seen = 1;
      cnt++;
      tick();
    end
    chk({name, "_len"}, cnt, 16);
    chk({name, "_ready_low"}, {31'b0, rdy_seen}, 0);
    chk({name, "_ready_after"}, {30'b0, ready_p1, ready_p0}, 32'h3);
  endtask

  // Applies one store or load and checks both latencies.
  task automatic run_vec(input vec_t v);
    chk({v.name, "_ready"}, {31'b0, ready_p1}, 1);
    access_mode = v.mode; Daddr = v.addr; datain = v.data; M_signed = v.sgn;
    wren = !v.ld; dreq = v.ld;
    tick();
    wren = 0; dreq = 0;
    chk({v.name, "_mis"}, {30'b0, mis_p1, mis_p0}, {30'b0, v.mis, v.mis});
    chk({v.name, "_mv_p0"}, {31'b0, mv_p0}, {31'b0, v.ld});
    if (v.ld) chk({v.name, "_mout_p0"}, MOUT_p0, v.exp);
    chk({v.name, "_mv_p1_early"}, {31'b0, mv_p1}, 0);
    tick();
    chk({v.name, "_mv_p1"}, {30'b0, mv_p1, mv_p0}, {30'b0, v.ld, 1'b0});
    if (v.ld) begin
      chk({v.name, "_mout_p1"}, MOUT_p1, v.exp);
      chk({v.name, "_hold_p0"}, MOUT_p0, v.exp);
    end
    $display("vec %s addr=%h mode=%0d MOUT_p1=%h MOUT_p0=%h", v.name, v.addr, v.mode, MOUT_p1, MOUT_p0);
  endtask

  initial begin
    vec_t v;
    int   nz;
    vecs[0]  = '{0, LONG, 6'h10, 32'h8123_45F6, 0, 32'h0,         0, "st_long10"};
    vecs[1]  = '{1, BYTE, 6'h13, 32'h0,         1, 32'hFFFF_FFF6, 0, "ld_byte13_s"};
    vecs[2]  = '{1, WORD, 6'h10, 32'h0,         0, 32'h0000_8123, 0, "ld_word10_u"};
    vecs[3]  = '{1, LONG, 6'h10, 32'h0,         0, 32'h8123_45F6, 0, "ld_long10"};
    vecs[4]  = '{1, BYTE, 6'h10, 32'h0,         1, 32'hFFFF_FF81, 0, "ld_byte10_s"};
    vecs[5]  = '{1, WORD, 6'h12, 32'h0,         1, 32'h0000_45F6, 0, "ld_word12_s"};
    vecs[6]  = '{1, BYTE, 6'h11, 32'h0,         0, 32'h0000_0023, 0, "ld_byte11_u"};
    vecs[7]  = '{0, LONG, 6'h10, 32'h0,         0, 32'h0,         0, "st_zero10"};
    vecs[8]  = '{0, BYTE, 6'h11, 32'h0000_00AA, 0, 32'h0,         0, "st_byte11"};
    vecs[9]  = '{1, LONG, 6'h10, 32'h0,         0, 32'h00AA_0000, 0, "ld_after_byte"};
    vecs[10] = '{1, WORD, 6'h11, 32'h0,         0, 32'h0,         1, "ld_word11_mis"};
    vecs[11] = '{0, LONG, 6'h12, 32'hFFFF_FFFF, 0, 32'h0,         1, "st_long12_mis"};
    vecs[12] = '{1, LONG, 6'h10, 32'h0,         0, 32'h00AA_0000, 0, "ld_unchanged"};
    vecs[13] = '{0, WORD, 6'h16, 32'h0000_BEEF, 0, 32'h0,         0, "st_word16"};
    vecs[14] = '{1, WORD, 6'h16, 32'h0,         1, 32'hFFFF_BEEF, 0, "ld_word16_s"};
    vecs[15] = '{1, LONG, 6'h14, 32'h0,         0, 32'h0000_BEEF, 0, "ld_long14"};
    vecs[16] = '{0, BYTE, 6'h1B, 32'h0000_007F, 0, 32'h0,         0, "st_byte1b"};
    vecs[17] = '{1, LONG, 6'h18, 32'h0,         0, 32'h0000_007F, 0, "ld_long18"};
    vecs[18] = '{1, LONG, 6'h12, 32'h0,         0, 32'h0,         1, "ld_long12_mis"};
    vecs[19] = '{1, BYTE, 6'h11, 32'h0,         1, 32'hFFFF_FFAA, 0, "ld_byte11_s"};

    reset_n = 0; Paddr = 0; Daddr = 0; datain = 0; access_mode = LONG;
    M_signed = 0; wren = 0; dreq = 0; write_busy = 0; uread_port = 0;
    tick(); tick();

    // Reset state
    chk("rst_ready", {31'b0, ready_p1}, 0);
    chk("rst_mv", {30'b0, mv_p1, mv_p0}, 0);
    chk("rst_mis", {31'b0, mis_p1}, 0);
    chk("rst_uart_we", {31'b0, uwe_p1}, 0);
    chk("rst_uart_wdata", {24'b0, uwd_p1}, 0);
    chk("rst_mout", MOUT_p1 | MOUT_p0, 0);
    chk("rst_clear_busy", {30'b0, cb_p1, cb_p0}, 32'h3);
    $display("reset ready=%b clear_busy=%b", ready_p1, cb_p1);

    reset_n = 1;
    wait_clear("clear1");

    // Every word reads zero after the clear
    nz = 0;
    for (int a = 0; a < 16; a++) begin
      Paddr = 6'(a << 2);
      tick();
      if (IR_p1 !== 32'h0 || IR_p0 !== 32'h0) nz++;
    end
    chk("clear_all_zero", nz, 0);
    $display("clear sweep nonzero_words=%0d", nz);

    for (int i = 0; i < 20; i++) run_vec(vecs[i]);

    // IR returns the same word one cycle after Paddr
    Paddr = 6'h10;
    tick();
    chk("ir_word10", IR_p1, 32'h00AA_0000);

    // Same-word store and fetch: IR sees the old data, then the new
    access_mode = LONG; Daddr = 6'h10; datain = 32'hCAFE_BABE; wren = 1;
    tick();
    wren = 0;
    chk("ir_collision_old", IR_p1, 32'h00AA_0000);
    tick();
    chk("ir_collision_new", IR_p1, 32'hCAFE_BABE);
    $display("collision IR old/new observed, IR=%h", IR_p1);

    // Store wins over load; no mout_valid from either instance
    access_mode = LONG; Daddr = 6'h1C; datain = 32'h1234_5678; wren = 1; dreq = 1;
    tick();
    wren = 0; dreq = 0;
    chk("prio_mv_c1", {30'b0, mv_p1, mv_p0}, 0);
    tick();
    chk("prio_mv_c2", {30'b0, mv_p1, mv_p0}, 0);
    v = '{1, LONG, 6'h1C, 32'h0, 0, 32'h1234_5678, 0, "ld_prio_store"};
    run_vec(v);

    // UART store while transmitter busy: stall, then a single strobe
    write_busy = 1;
    access_mode = BYTE; Daddr = 6'h3C; datain = 32'h0000_0041; wren = 1;
    tick();
    wren = 0;
    begin
      bit bad = 0;
      int pulses = 0;
      for (int c = 0; c < 4; c++) begin
        if (ready_p1 || ready_p0) bad = 1;
        if (uwe_p1) pulses++;
        tick();
      end
      if (ready_p1) bad = 1;
      chk("txwait_ready_low", {31'b0, bad}, 0);
      write_busy = 0;
      tick();
      chk("txwait_we", {30'b0, uwe_p1, uwe_p0}, 32'h3);
      chk("txwait_wdata", {24'b0, uwd_p1}, 32'h41);
      chk("txwait_ready", {31'b0, ready_p1}, 1);
      if (uwe_p1) pulses++;
      tick();
      if (uwe_p1) pulses++;
      chk("txwait_pulses", pulses, 1);
      $display("uart busy store: pulses=%0d wdata=%h", pulses, uwd_p1);
    end

    // Back-to-back UART stores with the transmitter idle
    access_mode = LONG; Daddr = 6'h3C; datain = 32'h0000_0042; wren = 1;
    tick();
    chk("uart_b2b_1", {23'b0, uwe_p1, uwd_p1}, 32'h142);
    datain = 32'h0000_0043;
    tick();
    wren = 0;
    chk("uart_b2b_2", {23'b0, uwe_p1, uwd_p1}, 32'h143);
    tick();
    chk("uart_b2b_end", {31'b0, uwe_p1}, 0);
    $display("uart back-to-back last wdata=%h", uwd_p1);

    // UART window load
    uread_port = 8'h5A; write_busy = 1;
    v = '{1, LONG, 6'h3C, 32'h0, 0, 32'h0000_015A, 0, "ld_uart"};
    run_vec(v);
    write_busy = 0;

    // UART stores never reached the RAM word behind the window
    Paddr = 6'h3C;
    tick();
    chk("uart_ram_untouched", IR_p1, 32'h0);

    // Asynchronous reset from RUN, then again mid-clear
    reset_n = 0;
    #1;
    chk("arst_mout", MOUT_p1 | MOUT_p0, 0);
    chk("arst_ready", {30'b0, ready_p1, ready_p0}, 0);
    chk("arst_uart_wdata", {24'b0, uwd_p1}, 0);
    tick();
    reset_n = 1;
    repeat (5) tick();
    chk("midclear_busy", {31'b0, cb_p1}, 1);
    reset_n = 0;
    #1;
    chk("midclear_ready", {31'b0, ready_p1}, 0);
    chk("midclear_mv_mis", {30'b0, mv_p1, mis_p1}, 0);
    tick();
    reset_n = 1;
    wait_clear("clear2");
    Paddr = 6'h10;
    tick();
    chk("reclear_word10", IR_p1, 32'h0);
    $display("reclear IR[0x10]=%h", IR_p1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
